// File: rtl/mem_responder.sv
// Tagged load/store backing memory: single-cycle tag grant, fixed-latency in-order returns.
// Optional refusal throttle for retry-path coverage: define MEM_RESP_THROTTLE_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 8
`endif

module mem_responder #(
    parameter int addr_size     = `XLEN,
    parameter int mem_data_size = 64,
    parameter int mem_tag_size  = `NUM_MEM_TAGS,
    parameter int latency       = 4,
    parameter int mem_depth     = 8192
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [addr_size-1:0]            addr_in,
    input  logic [1:0]                      mem_command,
    input  logic [mem_data_size-1:0]        data_in,
    output logic [$clog2(mem_tag_size):0]   mem_response,
    output logic [mem_data_size-1:0]        mem_data_out,
    output logic [$clog2(mem_tag_size):0]   mem_tag
);

    localparam int TAG_W  = $clog2(mem_tag_size) + 1;
    localparam int IDX_W  = $clog2(mem_depth);
    localparam int IDX_LO = $clog2(mem_data_size) - 3;
    localparam int CNT_W  = $clog2(mem_tag_size + 1);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [mem_data_size-1:0] mem [mem_depth];

    // Return pipeline: an accepted request enters stage 0 and reaches the
    // output stage latency-1 edges later, so it is visible exactly at T+latency.
    logic                     vld_p  [latency];
    logic [TAG_W-1:0]         tag_p  [latency];
    logic [mem_data_size-1:0] data_p [latency];

    logic [CNT_W-1:0]         pending;
    logic [CNT_W-1:0]         held;
    logic [TAG_W-1:0]         next_tag;
    logic [IDX_W-1:0]         word_idx;
    logic [mem_data_size-1:0] rd_word;
    logic                     is_load;
    logic                     is_store;
    logic                     throttle_ok;
    logic                     accept;
    logic                     unused_addr;

    assign unused_addr = ^addr_in;
    assign word_idx    = addr_in[IDX_LO +: IDX_W];
    assign rd_word     = mem[word_idx];
    assign is_load     = (mem_command == BUS_LOAD);
    assign is_store    = (mem_command == BUS_STORE);

    // The entry in the output stage retires this cycle, so its slot is reusable now.
    assign held   = pending - CNT_W'(vld_p[latency-1]);
    assign accept = reset && (mem_command != BUS_NONE) && (held < CNT_W'(mem_tag_size)) && throttle_ok;

    assign mem_response = accept ? next_tag : '0;
    assign mem_tag      = tag_p[latency-1];
    assign mem_data_out = data_p[latency-1];

`ifdef MEM_RESP_THROTTLE_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign throttle_ok = (lfsr[1:0] != 2'b00);
`else
    assign throttle_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (accept && is_store) begin
            mem[word_idx] <= data_in;
        end
    end

    // Stage 0 captures the read word at acceptance; later stores cannot disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            next_tag <= TAG_W'(1);
            for (int i = 0; i < latency; i++) begin
                vld_p[i]  <= 1'b0;
                tag_p[i]  <= '0;
                data_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= accept;
            tag_p[0]  <= (accept && is_load) ? next_tag : '0;
            data_p[0] <= (accept && is_load) ? rd_word : '0;
            for (int i = 1; i < latency; i++) begin
                vld_p[i]  <= vld_p[i-1];
                tag_p[i]  <= tag_p[i-1];
                data_p[i] <= data_p[i-1];
            end
            pending <= held + CNT_W'(accept);
            if (accept) begin
                next_tag <= (next_tag == TAG_W'(mem_tag_size)) ? TAG_W'(1) : next_tag + TAG_W'(1);
            end
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the tagged load/store bus used by the fetch and stream-buffer units. It accepts one `BUS_LOAD`/`BUS_STORE` per cycle and acknowledges it combinationally with a nonzero tag, or with 0 to refuse it. Loads return data after a fixed latency, strictly in acceptance order, tagged for the requester. It is the backing memory for unit and system benches, standing in for lower-level memory under the prefetchers.

## Interface
Parameters:
- `addr_size`, `` `XLEN ``: byte address width.
- `mem_data_size`, 64: bus data width in bits; word = one beat.
- `mem_tag_size`, `` `NUM_MEM_TAGS ``: number of usable tags (1..mem_tag_size); also the pending-queue depth.
- `latency`, 4: cycles from acceptance to data return; legal range ≥1.
- `mem_depth`, 8192: words of storage; power of two.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `addr_in` in addr_size: byte address of the request.
- `mem_command` in 2: `BUS_NONE`/`BUS_LOAD`/`BUS_STORE`.
- `data_in` in mem_data_size: store data.
- `mem_response` out $clog2(mem_tag_size)+1: combinational; the allocated tag, or 0 if refused or idle.
- `mem_data_out` out mem_data_size: registered load data.
- `mem_tag` out $clog2(mem_tag_size)+1: registered; tag of `mem_data_out`, 0 means no data this cycle.

## Operation
- Word index = `addr_in[$clog2(mem_data_size)-3 +: $clog2(mem_depth)]`. Low alignment bits and upper bits are ignored.
- Acceptance: a command is accepted iff it is not `BUS_NONE` and the pending count < mem_tag_size (and the throttle permits, see Configuration).
  - When accepted, `mem_response` = `next_tag`; otherwise `mem_response` = 0.
- `next_tag` resets to 1 and advances on each acceptance: 1,2,…,mem_tag_size,1,… (0 is never issued).
- Accepted load:
  - The storage word is read at acceptance.
  - An entry {tag, data, is_load=1, countdown=latency-1} is pushed to the pending FIFO.
  - A store accepted later to the same word does not alter this load's returned data.
- Accepted store:
  - The word is written at the accepting edge.
  - An entry {tag, is_load=0} is pushed, so it occupies its tag for `latency` cycles.
  - It returns no data.
- Each cycle, every entry's countdown decrements (saturating at 0).
  - If the head's countdown is 0, the head pops at the edge.
  - A load head drives `mem_tag`=tag and `mem_data_out`=data for the following cycle.
  - A store head pops silently (`mem_tag`=0).
- Tags free in FIFO order, so round-robin allocation never reissues a live tag.
- Push and pop in the same cycle are allowed when the FIFO is full: the pop frees the slot combinationally, so the push is accepted.
- Storage is not cleared by reset.
- Reset (any time): the FIFO is emptied, `next_tag`=1, `mem_tag`=0, `mem_data_out`=0, and in-flight requests are discarded.

## Timing
- `mem_response` is valid in the same cycle as `mem_command`.
- A load accepted in cycle T has `mem_tag`/`mem_data_out` valid for exactly one cycle, T+latency.
- A store accepted in cycle T is visible to a load accepted in cycle T+1.
- Returns are at most one per cycle. Returns are back-to-back when loads are accepted on consecutive cycles.
- Full throughput: one accepted request per cycle, sustained when latency ≤ mem_tag_size.
- Reset values of all outputs are 0; `mem_response` is 0 while `reset` is low.

## Configuration
- `MEM_RESP_THROTTLE_EN` defined:
  - An 8-bit Fibonacci LFSR (seed 8'hA5, taps 8,6,5,4) steps every cycle out of reset.
  - Any command arriving while `lfsr[1:0]==2'b00` is refused (`mem_response`=0), so requesters' retry paths get exercised.
- Undefined: no LFSR is instantiated, and refusal occurs only when the pending FIFO is full.

## Test plan
- Store 64'hDEAD_BEEF to 0x100 in cycle 0, load 0x100 in cycle 1 (latency=4). The load's response is 2, and `mem_tag`=2 with data 64'hDEAD_BEEF in cycle 5.
- Eight consecutive loads of 0x0,0x8,…,0x38 preloaded with 0..7 → responses 1..8, then tags 1..8 in cycles 4..11 carrying data 0..7 in order.
- mem_tag_size=15, latency=20, 16 back-to-back loads → the 16th is refused (response 0), re-accepted once tag 1 returns, and issued tag 1.
- Load 0x40 (old value 5), then store 9 to 0x40 the next cycle → the load returns 5; a later load returns 9.
- Assert reset low mid-burst with 3 loads pending → `mem_tag` goes to 0 immediately, and no returns appear after release. The first post-reset load gets tag 1.
- With `MEM_RESP_THROTTLE_EN` defined, issue a continuous load stream → refusals occur exactly in cycles where `lfsr[1:0]==0`, and every accepted tag returns once, in order.
